i2s_rx: RTL and testbench
=========================

# i2s_rx

I2S receiver: deserialises the serial data line into signed left/right sample pairs and hands each pair to downstream logic over a valid/ready handshake. It sits at the audio input edge, between the ADC pins and the FFT front end. It is the mirror of the existing I2S transmit path. `bclk`/`lrclk` come from `i2s_clkgen` (master mode) and are synchronous to `clk`.

## Interface
- `DATA_BITS`, 24 — valid bits per channel word, MSB first, 1..31.
- `clk`  in  1 — system clock; all logic on the rising edge.
- `rst`  in  1 — reset, synchronous, active-high.
- `bclk`  in  1 — I2S bit clock, synchronous to `clk`, high and low phases each ≥1 `clk` cycle.
- `lrclk`  in  1 — word select; 0 = left, 1 = right.
- `sdata`  in  1 — serial data from the ADC.
- `left_data`  out  DATA_BITS — captured left word.
- `right_data`  out  DATA_BITS — captured right word.
- `out_valid`  out  1 — the pair on `left_data`/`right_data` is valid.
- `out_ready`  in  1 — consumer accepts the pair.
- `overrun`  out  1 — sticky: an unaccepted pair was overwritten.
- `frame_err`  out  1 — one-cycle pulse: a slot was too short and its word was dropped.

## Operation
- **Edge detect:** register `bclk` into `bclk_q`. `rise = bclk & ~bclk_q`. On a `rise` cycle, sample `sdata` and `lrclk` together.
- **Slot tracking:** keep `ws_q`, the `lrclk` value at the previous rise.
  - A rise where `lrclk != ws_q` is a slot boundary. At that rise, `bit_cnt` goes to 0 and the slot's channel is the new `lrclk`.
  - Other rises increment `bit_cnt`, which saturates at 63 (6 bits).
- **Bit placement (I2S one-bit delay):**
  - `bit_cnt` 0 carries the previous slot's trailing bit and is ignored.
  - `bit_cnt` 1..DATA_BITS shift into the shift register, MSB first.
  - `bit_cnt` > DATA_BITS is ignored (padding).
- **Word capture:** when `bit_cnt == DATA_BITS` is sampled, move the shift register to `left_hold` (channel 0) or to the output stage (channel 1).
- **Pairing state machine:** states `UNLOCKED`, `WAIT_LEFT`, `WAIT_RIGHT`.
  - `UNLOCKED` → `WAIT_LEFT` on the first slot boundary after reset.
  - `WAIT_LEFT` → `WAIT_RIGHT` when a left word completes.
  - `WAIT_RIGHT` → `WAIT_LEFT` when a right word completes; this publishes `left_hold` plus the right word to the outputs and sets `out_valid`.
  - A right word completing in `WAIT_LEFT` is discarded (no output).
  - A left word completing in `WAIT_RIGHT` replaces `left_hold`.
- **Short slot:** a slot boundary while `bit_cnt < DATA_BITS`, in a slot that started after lock, pulses `frame_err`. The partial word is dropped and the state machine returns to `WAIT_LEFT`.
- **Handshake:**
  - `out_valid` stays high, and `left_data`/`right_data` stay stable, until a cycle with `out_valid & out_ready`. `out_valid` falls on the next edge.
  - If a new pair is published while `out_valid` is high and `out_ready` is low, the new pair overwrites the outputs, `out_valid` stays high, and `overrun` sets.
  - If publish and accept happen in the same cycle, the new pair is loaded and `out_valid` stays high. This is not an overrun.
- **Reset:** `overrun` clears only on `rst`.

## Timing
- **Reset values:** `left_data`, `right_data` = 0; `out_valid` = 0; `overrun` = 0; `frame_err` = 0; state = `UNLOCKED`; `bit_cnt` = 0; `bclk_q`, `ws_q` = 0.
- **Reset mid-frame:** the partial word is discarded and no output is produced until a new lock.
- **Latency:** `out_valid` rises 1 `clk` after the `rise` cycle that samples right bit `DATA_BITS` (the right LSB). `frame_err` is asserted for exactly the 1 cycle after the offending `rise` cycle.
- **Sampling point:** `sdata` is sampled once per `bclk` period, on the `clk` cycle where `bclk` is first seen high. `bclk`/`lrclk`/`sdata` have no synchronisers; asynchronous slave-mode inputs need external 2-FF synchronisation.
- **Sign:** words are two's complement and passed through without sign extension.

## Structure
- Package `i2s_pkg` holds:
  - the `CH_LEFT=0`/`CH_RIGHT=1` constants;
  - the pairing-state enum;
  - `BIT_CNT_W=6`, which is shared with `i2s_tx`/`i2s_clkgen`.
- Sub-module `i2s_rx_shift` contains the edge detect, `ws_q`, `bit_cnt`, the shift register, the boundary detect and the short-slot detect. It emits `word_done`, `word_ch`, `word` and `slot_short`.
- The top level owns the pairing state machine and the output handshake.
- Test wrapper `i2s_loopback_top` wires `i2s_clkgen` → `i2s_tx` → `i2s_rx`, with `tx.sdata` connected to `rx.sdata`.

## Test plan
- **Loopback, nominal:** `CLK_DIV=2`, `DATA_BITS=24`, tx left=24'h123456, right=24'hABCDEF, `out_ready`=1 → every frame after the first full one shows `out_valid` pulses with left 24'h123456 / right 24'hABCDEF; `frame_err`=0; `overrun`=0.
- **Extreme values:** left=24'h800000, right=24'h7FFFFF, then left=24'hFFFFFF, right=0 → bit-exact capture and sign preserved.
- **Backpressure:** `out_ready`=0 for 3 frames → `out_valid` stays high and the outputs hold the latest pair. `overrun`=1 after the second frame and stays 1 after `out_ready` returns, until `rst`.
- **Short slot:** a bench-driven `lrclk` toggles after 10 bits of a left slot → one `frame_err` pulse and no output for that frame; the next clean frame is published normally.
- **Mid-frame start:** release reset in the middle of a right slot → the first output pair comes from the first complete left+right sequence and no partial word is ever published.
- **Reset mid-frame:** assert `rst` for 1 cycle during left bit 12 → all outputs 0 on the next cycle; relock and correct data within 2 frames.

Source files
------------

// File: rtl/i2s_pkg.sv
// Shared I2S definitions: channel codes, pairing states, bit counter width.
package i2s_pkg;

    // Width of the per-slot bit counter, shared with the transmit and clock-generator blocks.
    localparam int unsigned BIT_CNT_W = 6;

    localparam logic CH_LEFT  = 1'b0;
    localparam logic CH_RIGHT = 1'b1;

    typedef enum logic [1:0] {
        StUnlocked,
        StWaitLeft,
        StWaitRight
    } pair_state_e;

endpackage

// File: rtl/i2s_rx_shift.sv
// I2S slot tracker and deserialiser.
// This block detects bclk edges, finds slot boundaries and counts bits within a slot.
// It assembles each channel word, MSB first.
module i2s_rx_shift
    import i2s_pkg::*;
#(
    parameter int unsigned DATA_BITS = 24
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 bclk,
    input  logic                 lrclk,
    input  logic                 sdata,
    output logic                 slot_start,
    output logic                 word_done,
    output logic                 word_ch,
    output logic [DATA_BITS-1:0] word,
    output logic                 slot_short
);

    // The stored part of the word excludes the bit arriving this cycle.
    localparam int unsigned ShW = (DATA_BITS > 1) ? DATA_BITS - 1 : 1;
    localparam logic [BIT_CNT_W-1:0] LastBit = BIT_CNT_W'(DATA_BITS);
    localparam logic [BIT_CNT_W-1:0] CntMax  = '1;

    logic                 bclk_q, bclk_d;
    logic                 ws_q, ws_d;
    logic                 ch_q, ch_d;
    logic                 locked_q, locked_d;
    // The current slot began at a boundary seen while already locked.
    logic                 chk_q, chk_d;
    logic [BIT_CNT_W-1:0] bit_cnt_q, bit_cnt_d;
    logic [ShW-1:0]       shift_q, shift_d;

    logic                 rise;
    logic                 boundary;
    logic [BIT_CNT_W-1:0] cnt_next;
    logic [ShW:0]         word_full;

    // Next-state logic: edge detect, boundary detect, bit placement and word completion.
    always_comb begin
        rise       = bclk & ~bclk_q;
        boundary   = rise & (lrclk != ws_q);
        cnt_next   = (bit_cnt_q == CntMax) ? bit_cnt_q : bit_cnt_q + 1'b1;
        word_full  = {shift_q, sdata};

        bclk_d     = bclk;
        ws_d       = ws_q;
        ch_d       = ch_q;
        locked_d   = locked_q;
        chk_d      = chk_q;
        bit_cnt_d  = bit_cnt_q;
        shift_d    = shift_q;
        word_done  = 1'b0;
        slot_short = 1'b0;
        slot_start = boundary;
        word_ch    = ch_q;
        word       = word_full[DATA_BITS-1:0];

        if (rise) begin
            ws_d = lrclk;
        end

        if (boundary) begin
            // Bit 0 of a slot carries the previous slot's trailing bit and is dropped.
            bit_cnt_d  = '0;
            ch_d       = lrclk;
            locked_d   = 1'b1;
            chk_d      = locked_q;
            slot_short = chk_q & (bit_cnt_q < LastBit);
        end else if (rise) begin
            bit_cnt_d = cnt_next;
            if (cnt_next <= LastBit) begin
                shift_d = word_full[ShW-1:0];
            end
            word_done = (cnt_next == LastBit);
        end
    end

    // State registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            bclk_q    <= 1'b0;
            ws_q      <= 1'b0;
            ch_q      <= CH_LEFT;
            locked_q  <= 1'b0;
            chk_q     <= 1'b0;
            bit_cnt_q <= '0;
            shift_q   <= '0;
        end else begin
            bclk_q    <= bclk_d;
            ws_q      <= ws_d;
            ch_q      <= ch_d;
            locked_q  <= locked_d;
            chk_q     <= chk_d;
            bit_cnt_q <= bit_cnt_d;
            shift_q   <= shift_d;
        end
    end

endmodule

// File: rtl/i2s_rx.sv
// I2S receiver top level.
// It pairs left and right words, then presents each pair on a valid/ready output
// and flags overruns and short slots.
module i2s_rx
    import i2s_pkg::*;
#(
    parameter int unsigned DATA_BITS = 24
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 bclk,
    input  logic                 lrclk,
    input  logic                 sdata,
    output logic [DATA_BITS-1:0] left_data,
    output logic [DATA_BITS-1:0] right_data,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic                 overrun,
    output logic                 frame_err
);

    logic                 slot_start;
    logic                 word_done;
    logic                 word_ch;
    logic [DATA_BITS-1:0] word;
    logic                 slot_short;

    pair_state_e          state_q, state_d;
    logic [DATA_BITS-1:0] left_hold_q, left_hold_d;
    logic [DATA_BITS-1:0] left_data_q, left_data_d;
    logic [DATA_BITS-1:0] right_data_q, right_data_d;
    logic                 out_valid_q, out_valid_d;
    logic                 overrun_q, overrun_d;
    logic                 frame_err_q, frame_err_d;

    i2s_rx_shift #(
        .DATA_BITS (DATA_BITS)
    ) u_shift (
        .clk        (clk),
        .rst        (rst),
        .bclk       (bclk),
        .lrclk      (lrclk),
        .sdata      (sdata),
        .slot_start (slot_start),
        .word_done  (word_done),
        .word_ch    (word_ch),
        .word       (word),
        .slot_short (slot_short)
    );

    // Pairing state machine and output handshake next-state logic.
    always_comb begin
        state_d      = state_q;
        left_hold_d  = left_hold_q;
        left_data_d  = left_data_q;
        right_data_d = right_data_q;
        out_valid_d  = out_valid_q;
        overrun_d    = overrun_q;
        frame_err_d  = 1'b0;

        if (out_valid_q && out_ready) begin
            out_valid_d = 1'b0;
        end

        if (slot_short) begin
            frame_err_d = 1'b1;
            state_d     = StWaitLeft;
        end else if (slot_start && (state_q == StUnlocked)) begin
            state_d = StWaitLeft;
        end else if (word_done) begin
            case (state_q)
                StWaitLeft: begin
                    // A right word with no preceding left word is discarded.
                    if (word_ch == CH_LEFT) begin
                        left_hold_d = word;
                        state_d     = StWaitRight;
                    end
                end
                StWaitRight: begin
                    if (word_ch == CH_LEFT) begin
                        left_hold_d = word;
                    end else begin
                        left_data_d  = left_hold_q;
                        right_data_d = word;
                        out_valid_d  = 1'b1;
                        // Same-cycle accept frees the slot, so only an unaccepted pair is lost.
                        if (out_valid_q && !out_ready) begin
                            overrun_d = 1'b1;
                        end
                        state_d = StWaitLeft;
                    end
                end
                default: ;
            endcase
        end
    end

    // Register state and outputs with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= StUnlocked;
            left_hold_q  <= '0;
            left_data_q  <= '0;
            right_data_q <= '0;
            out_valid_q  <= 1'b0;
            overrun_q    <= 1'b0;
            frame_err_q  <= 1'b0;
        end else begin
            state_q      <= state_d;
            left_hold_q  <= left_hold_d;
            left_data_q  <= left_data_d;
            right_data_q <= right_data_d;
            out_valid_q  <= out_valid_d;
            overrun_q    <= overrun_d;
            frame_err_q  <= frame_err_d;
        end
    end

    assign left_data  = left_data_q;
    assign right_data = right_data_q;
    assign out_valid  = out_valid_q;
    assign overrun    = overrun_q;
    assign frame_err  = frame_err_q;

endmodule

// File: tb/tb_i2s_rx.sv
// Directed bench for i2s_rx.
// The bench drives an I2S stream with 32-bit slots and a bclk period of 4 clk.
module tb_i2s_rx;

    localparam int unsigned DW = 24;
    localparam int SlotBits = 32;

    logic          clk = 1'b0;
    logic          rst;
    logic          bclk;
    logic          lrclk;
    logic          sdata;
    logic          out_ready;
    logic [DW-1:0] left_data;
    logic [DW-1:0] right_data;
    logic          out_valid;
    logic          overrun;
    logic          frame_err;

    always #5 clk = ~clk;

    int unsigned cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    i2s_rx #(
        .DATA_BITS (DW)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .bclk       (bclk),
        .lrclk      (lrclk),
        .sdata      (sdata),
        .left_data  (left_data),
        .right_data (right_data),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .overrun    (overrun),
        .frame_err  (frame_err)
    );

    int errors = 0;
    int checks = 0;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Accepted pairs, frame_err pulse count and out_valid rise time.
    logic [DW-1:0] ql[$];
    logic [DW-1:0] qr[$];
    int            fe_cnt = 0;
    int unsigned   rise_cyc = 0;
    int unsigned   lsb_cyc = 0;
    logic          ov_prev = 1'b0;

    always @(negedge clk) begin
        if (out_valid && out_ready) begin
            ql.push_back(left_data);
            qr.push_back(right_data);
        end
        if (frame_err) fe_cnt++;
        if (out_valid && !ov_prev) rise_cyc = cyc;
        ov_prev = out_valid;
    end

    function automatic logic [DW-1:0] get_l(input int i);
        return (i < ql.size()) ? ql[i] : 'x;
    endfunction

    function automatic logic [DW-1:0] get_r(input int i);
        return (i < qr.size()) ? qr[i] : 'x;
    endfunction

    task automatic clear_q();
        ql.delete();
        qr.delete();
    endtask

    // One bclk period: low for two clk edges, then high for two clk edges.
    task automatic send_bit(input logic lr, input logic sd, input bit do_rst, input bit mark);
        @(posedge clk); #1;
        bclk = 1'b0; lrclk = lr; sdata = sd;
        if (do_rst) rst = 1'b1;
        @(posedge clk); #1;
        if (do_rst) begin
            rst = 1'b0;
            @(negedge clk);
            check_eq("outputs_zero_after_reset",
                     64'({left_data, right_data, out_valid, overrun, frame_err}), 64'd0);
        end
        @(posedge clk); #1;
        bclk = 1'b1;
        if (mark) lsb_cyc = cyc;
        @(posedge clk);
    endtask

    // Slot bit 0 and the padding bits are driven high, so any use of them shows up in the data.
    task automatic send_slot(input logic ch, input logic [DW-1:0] w, input int nbits,
                             input int rst_bit, input bit mark_lsb);
        for (int i = 0; i < nbits; i++) begin
            logic sd;
            if (i >= 1 && i <= int'(DW)) sd = w[int'(DW) - i];
            else sd = 1'b1;
            send_bit(ch, sd, i == rst_bit, mark_lsb && (i == int'(DW)));
        end
    endtask

    task automatic send_frame(input logic [DW-1:0] l, input logic [DW-1:0] r, input bit mark);
        send_slot(1'b0, l, SlotBits, -1, 1'b0);
        send_slot(1'b1, r, SlotBits, -1, mark);
    endtask

    initial begin
        #1_000_000;
        errors++;
        $display("FAIL watchdog: got timeout expected completion");
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $fatal(1, "watchdog");
    end

    initial begin
        int fe0;
        rst = 1'b1; bclk = 1'b0; lrclk = 1'b0; sdata = 1'b0; out_ready = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_eq("rst_left",      64'(left_data),  64'd0);
        check_eq("rst_right",     64'(right_data), 64'd0);
        check_eq("rst_valid",     64'(out_valid),  64'd0);
        check_eq("rst_overrun",   64'(overrun),    64'd0);
        check_eq("rst_frame_err", 64'(frame_err),  64'd0);
        rst = 1'b0;

        // Nominal: the first frame only locks, the next two are published.
        clear_q();
        send_frame(24'h123456, 24'hABCDEF, 1'b0);
        send_frame(24'h123456, 24'hABCDEF, 1'b0);
        send_frame(24'h123456, 24'hABCDEF, 1'b1);
        check_eq("nom_count",   64'(ql.size()), 64'd2);
        check_eq("nom_l0",      64'(get_l(0)),  64'h123456);
        check_eq("nom_r0",      64'(get_r(0)),  64'hABCDEF);
        check_eq("nom_l1",      64'(get_l(1)),  64'h123456);
        check_eq("nom_r1",      64'(get_r(1)),  64'hABCDEF);
        check_eq("nom_fe",      64'(fe_cnt),    64'd0);
        check_eq("nom_overrun", 64'(overrun),   64'd0);
        check_eq("nom_latency", 64'(rise_cyc),  64'(lsb_cyc + 1));

        // Extreme values.
        clear_q();
        send_frame(24'h800000, 24'h7FFFFF, 1'b0);
        send_frame(24'hFFFFFF, 24'h000000, 1'b0);
        check_eq("ext_count", 64'(ql.size()), 64'd2);
        check_eq("ext_l0",    64'(get_l(0)),  64'h800000);
        check_eq("ext_r0",    64'(get_r(0)),  64'h7FFFFF);
        check_eq("ext_l1",    64'(get_l(1)),  64'hFFFFFF);
        check_eq("ext_r1",    64'(get_r(1)),  64'h000000);

        // Backpressure across three frames.
        clear_q();
        #1 out_ready = 1'b0;
        send_frame(24'h111111, 24'h222222, 1'b0);
        check_eq("bp1_valid",   64'(out_valid),  64'd1);
        check_eq("bp1_overrun", 64'(overrun),    64'd0);
        check_eq("bp1_left",    64'(left_data),  64'h111111);
        check_eq("bp1_right",   64'(right_data), 64'h222222);
        send_frame(24'h333333, 24'h444444, 1'b0);
        check_eq("bp2_overrun", 64'(overrun),    64'd1);
        check_eq("bp2_left",    64'(left_data),  64'h333333);
        send_frame(24'h555555, 24'h666666, 1'b0);
        check_eq("bp3_valid",   64'(out_valid),  64'd1);
        check_eq("bp3_left",    64'(left_data),  64'h555555);
        check_eq("bp3_right",   64'(right_data), 64'h666666);
        #1 out_ready = 1'b1;
        repeat (2) @(negedge clk);
        check_eq("bp_accept_count", 64'(ql.size()), 64'd1);
        check_eq("bp_accept_l",     64'(get_l(0)),  64'h555555);
        check_eq("bp_accept_r",     64'(get_r(0)),  64'h666666);
        check_eq("bp_valid_low",    64'(out_valid), 64'd0);
        check_eq("bp_overrun_held", 64'(overrun),   64'd1);

        // Reset during left bit 12 with a pair pending, then relock.
        #1 out_ready = 1'b0;
        send_frame(24'h777777, 24'h888888, 1'b0);
        check_eq("rmf_pending", 64'(out_valid), 64'd1);
        clear_q();
        send_slot(1'b0, 24'h999999, SlotBits, 12, 1'b0);
        #1 out_ready = 1'b1;
        fe0 = fe_cnt;
        send_slot(1'b1, 24'hAAAAAA, SlotBits, -1, 1'b0);
        send_frame(24'h121212, 24'h343434, 1'b0);
        send_frame(24'h565656, 24'h787878, 1'b0);
        check_eq("rmf_count",   64'(ql.size()),    64'd2);
        check_eq("rmf_l0",      64'(get_l(0)),     64'h121212);
        check_eq("rmf_r0",      64'(get_r(0)),     64'h343434);
        check_eq("rmf_l1",      64'(get_l(1)),     64'h565656);
        check_eq("rmf_r1",      64'(get_r(1)),     64'h787878);
        check_eq("rmf_overrun", 64'(overrun),      64'd0);
        check_eq("rmf_fe",      64'(fe_cnt - fe0), 64'd0);

        // Short left slot: 10 data bits, then a full right slot.
        clear_q();
        fe0 = fe_cnt;
        send_slot(1'b0, 24'h0F0F0F, 11, -1, 1'b0);
        send_slot(1'b1, 24'hF0F0F0, SlotBits, -1, 1'b0);
        check_eq("short_fe",     64'(fe_cnt - fe0), 64'd1);
        check_eq("short_no_out", 64'(ql.size()),    64'd0);
        send_frame(24'h135790, 24'h2468AC, 1'b0);
        check_eq("short_next_count", 64'(ql.size()), 64'd1);
        check_eq("short_next_l",     64'(get_l(0)),  64'h135790);
        check_eq("short_next_r",     64'(get_r(0)),  64'h2468AC);

        // Reset released in the middle of a right slot.
        clear_q();
        fe0 = fe_cnt;
        send_slot(1'b0, 24'h111000, SlotBits, -1, 1'b0);
        send_slot(1'b1, 24'h222000, SlotBits, 6, 1'b0);
        check_eq("mid_no_partial", 64'(ql.size()), 64'd0);
        send_frame(24'hABC123, 24'hDEF456, 1'b0);
        check_eq("mid_count", 64'(ql.size()),    64'd1);
        check_eq("mid_l",     64'(get_l(0)),     64'hABC123);
        check_eq("mid_r",     64'(get_r(0)),     64'hDEF456);
        check_eq("mid_fe",    64'(fe_cnt - fe0), 64'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
